// File: rtl/wb_shared_bus.sv
// Shared Wishbone bus: round-robin arbitration among NM masters, address decode to NS slaves.
// Optional slave watchdog enabled by defining WB_SHARED_BUS_TIMEOUT_EN.
module wb_shared_bus #(
   parameter int NM = 2,
   parameter int NS = 3,
   parameter int AW = 24,
   parameter int DW = 16,
   parameter logic [NS*AW-1:0] SLV_BASE = {24'hFF0000, 24'h400000, 24'h000000},
   parameter logic [NS*AW-1:0] SLV_MASK = {24'hFF0000, 24'hC00000, 24'hC00000},
   parameter int TIMEOUT = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NM-1:0]      m_cyc_i,
   input  logic [NM-1:0]      m_stb_i,
   input  logic [NM-1:0]      m_we_i,
   input  logic [NM*AW-1:0]   m_adr_i,
   input  logic [NM*DW-1:0]   m_dat_i,
   input  logic [NM*DW/8-1:0] m_sel_i,
   output logic [DW-1:0]      m_dat_o,
   output logic [NM-1:0]      m_ack_o,
   output logic [NM-1:0]      m_err_o,
   output logic [NM-1:0]      m_rty_o,
   output logic [NS-1:0]      s_cyc_o,
   output logic [NS-1:0]      s_stb_o,
   output logic               s_we_o,
   output logic [AW-1:0]      s_adr_o,
   output logic [DW-1:0]      s_dat_o,
   output logic [DW/8-1:0]    s_sel_o,
   input  logic [NS*DW-1:0]   s_dat_i,
   input  logic [NS-1:0]      s_ack_i,
   input  logic [NS-1:0]      s_err_i,
   input  logic [NS-1:0]      s_rty_i,
   output logic [NM-1:0]      gnt_o
);

   localparam int SW  = DW / 8;
   localparam int MIW = $clog2(NM);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t         state_reg, state_next;
   logic [NM-1:0]  gnt_reg, gnt_next;
   logic [MIW-1:0] last_reg, last_next;
   logic [MIW-1:0] win;
   logic           found;
   logic           gnt_cyc, gnt_stb;
   logic [NS-1:0]  hit;
   logic           any_hit;
   logic           sel_ack, sel_err, sel_rty;
   logic           term_valid, decode_err, tmo_fire;

   // Round-robin search starting just after the previous winner
   always_comb begin
      int idx;
      found = 1'b0;
      win   = last_reg;
      for (int k = 1; k <= NM; k++) begin
         idx = (int'(last_reg) + k) % NM;
         if (!found && m_cyc_i[idx]) begin
            found = 1'b1;
            win   = MIW'(idx);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         gnt_reg   <= '0;
         last_reg  <= MIW'(NM - 1);
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         last_reg  <= last_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next = OWNED;
               gnt_next   = {{(NM-1){1'b0}}, 1'b1} << win;
               last_next  = win;
            end
         end
         OWNED: begin
            // The owner keeps the bus for as long as its cyc stays high
            if (!gnt_cyc) begin
               if (found) begin
                  gnt_next  = {{(NM-1){1'b0}}, 1'b1} << win;
                  last_next = win;
               end else begin
                  state_next = IDLE;
                  gnt_next   = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase
   end

   assign gnt_o = gnt_reg;

   always_comb begin
      gnt_cyc = 1'b0;
      gnt_stb = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      for (int i = 0; i < NM; i++) begin
         if (gnt_reg[i]) begin
            gnt_cyc = m_cyc_i[i];
            gnt_stb = m_cyc_i[i] & m_stb_i[i];
            s_we_o  = m_we_i[i];
            s_adr_o = m_adr_i[i*AW +: AW];
            s_dat_o = m_dat_i[i*DW +: DW];
            s_sel_o = m_sel_i[i*SW +: SW];
         end
      end
   end

   // Lowest-numbered matching slave wins when windows overlap
   always_comb begin
      hit     = '0;
      any_hit = 1'b0;
      for (int j = 0; j < NS; j++) begin
         if (|gnt_reg && !any_hit &&
             ((s_adr_o & SLV_MASK[j*AW +: AW]) == SLV_BASE[j*AW +: AW])) begin
            hit[j]  = 1'b1;
            any_hit = 1'b1;
         end
      end
   end

   always_comb begin
      sel_ack = 1'b0;
      sel_err = 1'b0;
      sel_rty = 1'b0;
      m_dat_o = '0;
      for (int j = 0; j < NS; j++) begin
         if (hit[j]) begin
            sel_ack = s_ack_i[j];
            sel_err = s_err_i[j];
            sel_rty = s_rty_i[j];
            m_dat_o = s_dat_i[j*DW +: DW];
         end
      end
   end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
   logic [15:0] tmo_cnt_reg;
   logic        waiting;

   assign waiting  = gnt_stb & any_hit & ~(sel_ack | sel_err | sel_rty);
   assign tmo_fire = gnt_stb & any_hit & (tmo_cnt_reg == 16'(TIMEOUT));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         tmo_cnt_reg <= '0;
      else if (tmo_fire || !waiting)
         tmo_cnt_reg <= '0;
      else
         tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT != 0);
   assign tmo_fire   = 1'b0;
`endif

   // Responses count only while the owner's cycle is open and no watchdog abort is in progress
   assign term_valid = gnt_cyc & ~tmo_fire;
   assign decode_err = gnt_stb & ~any_hit;

   assign s_cyc_o = hit & {NS{gnt_cyc}};
   assign s_stb_o = hit & {NS{gnt_stb & ~tmo_fire}};
   assign m_ack_o = gnt_reg & {NM{sel_ack & term_valid}};
   assign m_rty_o = gnt_reg & {NM{sel_rty & term_valid}};
   assign m_err_o = gnt_reg & {NM{(sel_err & term_valid) | decode_err | tmo_fire}};

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus: arbitration, bus lock, decode, watchdog and reset.
// Instance b differs only in slave 0 base (0x800000) so 0x000100 is unmapped there.
module tb_wb_shared_bus;
   localparam int NM = 2;
   localparam int NS = 3;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int SW = 2;
   localparam logic [NS*AW-1:0] BASE_A = {24'hFF0000, 24'h400000, 24'h000000};
   localparam logic [NS*AW-1:0] BASE_B = {24'hFF0000, 24'h400000, 24'h800000};
   localparam logic [NS*AW-1:0] MASK   = {24'hFF0000, 24'hC00000, 24'hC00000};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NM-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
   logic [NM*AW-1:0] m_adr = '0;
   logic [NM*DW-1:0] m_dat = '0;
   logic [NM*SW-1:0] m_sel = '0;
   logic [NS*DW-1:0] s_dat = {16'hA002, 16'hA001, 16'hA000};
   logic [NS-1:0]    ack_force = '0;
   logic             ack_en = 1'b0;
   logic [NS-1:0]    s_zero = '0;

   logic [DW-1:0] a_m_dat, b_m_dat;
   logic [NM-1:0] a_m_ack, a_m_err, a_m_rty, a_gnt, b_m_ack, b_m_err, b_m_rty, b_gnt;
   logic [NS-1:0] a_s_cyc, a_s_stb, b_s_cyc, b_s_stb, a_s_ack, b_s_ack;
   logic          a_s_we, b_s_we;
   logic [AW-1:0] a_s_adr, b_s_adr;
   logic [DW-1:0] a_s_dat, b_s_dat;
   logic [SW-1:0] a_s_sel, b_s_sel;

   int vectors = 0;
   int miscompares = 0;

   assign a_s_ack = ack_force | (a_s_stb & {NS{ack_en}});
   assign b_s_ack = ack_force | (b_s_stb & {NS{ack_en}});

   always #5 clk = ~clk;

   wb_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SLV_BASE(BASE_A),
                   .SLV_MASK(MASK), .TIMEOUT(8)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
      .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(a_m_dat),
      .m_ack_o(a_m_ack), .m_err_o(a_m_err), .m_rty_o(a_m_rty),
      .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr),
      .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_dat_i(s_dat),
      .s_ack_i(a_s_ack), .s_err_i(s_zero), .s_rty_i(s_zero), .gnt_o(a_gnt)
   );

   wb_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SLV_BASE(BASE_B),
                   .SLV_MASK(MASK), .TIMEOUT(8)) u_dut_b (
      .clk_i(clk), .rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
      .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(b_m_dat),
      .m_ack_o(b_m_ack), .m_err_o(b_m_err), .m_rty_o(b_m_rty),
      .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr),
      .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_dat_i(s_dat),
      .s_ack_i(b_s_ack), .s_err_i(s_zero), .s_rty_i(s_zero), .gnt_o(b_gnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive(input int i, input logic cyc, input logic stb, input logic [AW-1:0] adr);
      m_cyc[i] = cyc;
      m_stb[i] = stb;
      m_adr[i*AW +: AW] = adr;
   endtask

   task automatic test_reset();
      mid();
      vectors++;
      if ({a_gnt, a_s_cyc, a_m_ack, a_m_err, a_s_adr} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got gnt=%b s_cyc=%b ack=%b err=%b adr=%h want all zero",
                  a_gnt, a_s_cyc, a_m_ack, a_m_err, a_s_adr);
      end
      m_cyc = 2'b11;
      tick();
      mid();
      vectors++;
      if ({a_gnt, a_s_cyc} !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_hold: got gnt=%b s_cyc=%b want 00 000", a_gnt, a_s_cyc);
      end
      m_cyc = '0;
      rst = 1'b0;
   endtask

   task automatic test_arbitration();
      tick();
      drive(0, 1'b1, 1'b1, 24'h000010);
      drive(1, 1'b1, 1'b1, 24'h400020);
      mid();
      vectors++;
      if (a_gnt !== 2'b00) begin
         miscompares++;
         $display("FAIL grant_latency: got gnt=%b want 00", a_gnt);
      end
      tick();
      mid();
      vectors++;
      if ({a_gnt, a_s_cyc, a_s_adr} !== {2'b01, 3'b001, 24'h000010}) begin
         miscompares++;
         $display("FAIL first_grant: got gnt=%b s_cyc=%b adr=%h want 01 001 000010",
                  a_gnt, a_s_cyc, a_s_adr);
      end
      tick();
      drive(0, 1'b0, 1'b0, 24'h000010);
      ack_force = 3'b001;
      mid();
      vectors++;
      if ({a_gnt, a_s_cyc, a_m_ack} !== {2'b01, 3'b000, 2'b00}) begin
         miscompares++;
         $display("FAIL stale_ack_discard: got gnt=%b s_cyc=%b ack=%b want 01 000 00",
                  a_gnt, a_s_cyc, a_m_ack);
      end
      ack_force = '0;
      tick();
      mid();
      vectors++;
      if ({a_gnt, a_s_cyc, a_s_adr} !== {2'b10, 3'b010, 24'h400020}) begin
         miscompares++;
         $display("FAIL handover: got gnt=%b s_cyc=%b adr=%h want 10 010 400020",
                  a_gnt, a_s_cyc, a_s_adr);
      end
      tick();
      drive(1, 1'b0, 1'b0, 24'h400020);
      tick();
      mid();
      vectors++;
      if (a_gnt !== 2'b00) begin
         miscompares++;
         $display("FAIL release_idle: got gnt=%b want 00", a_gnt);
      end
   endtask

   task automatic test_bus_lock();
      ack_en = 1'b1;
      tick();
      drive(1, 1'b1, 1'b0, 24'h000040);
      tick();
      drive(0, 1'b1, 1'b1, 24'h400000);
      for (int s = 0; s < 4; s++) begin
         m_stb[1] = 1'b1;
         mid();
         vectors++;
         if ({a_gnt, a_m_ack, a_s_stb} !== {2'b10, 2'b10, 3'b001}) begin
            miscompares++;
            $display("FAIL lock_strobe%0d: got gnt=%b ack=%b s_stb=%b want 10 10 001",
                     s, a_gnt, a_m_ack, a_s_stb);
         end
         tick();
         m_stb[1] = 1'b0;
         mid();
         vectors++;
         if ({a_gnt, a_m_ack, a_s_stb} !== {2'b10, 2'b00, 3'b000}) begin
            miscompares++;
            $display("FAIL lock_gap%0d: got gnt=%b ack=%b s_stb=%b want 10 00 000",
                     s, a_gnt, a_m_ack, a_s_stb);
         end
         tick();
      end
      m_cyc[1] = 1'b0;
      mid();
      vectors++;
      if ({a_gnt, a_s_cyc} !== {2'b10, 3'b000}) begin
         miscompares++;
         $display("FAIL lock_release: got gnt=%b s_cyc=%b want 10 000", a_gnt, a_s_cyc);
      end
      tick();
      mid();
      vectors++;
      if ({a_gnt, a_s_cyc, a_m_ack} !== {2'b01, 3'b010, 2'b01}) begin
         miscompares++;
         $display("FAIL lock_handover: got gnt=%b s_cyc=%b ack=%b want 01 010 01",
                  a_gnt, a_s_cyc, a_m_ack);
      end
      tick();
      drive(0, 1'b0, 1'b0, 24'h0);
      tick();
   endtask

   task automatic test_decode();
      ack_en = 1'b1;
      drive(0, 1'b1, 1'b1, 24'hFF0010);
      m_we[0] = 1'b1;
      m_dat[15:0] = 16'h1234;
      m_sel[1:0] = 2'b10;
      tick();
      mid();
      // 0xFF0010 matches only slave 2 under this map (top bits 11 miss slaves 0 and 1)
      vectors++;
      if ({a_s_cyc, a_m_dat, a_m_ack, b_s_cyc} !== {3'b100, 16'hA002, 2'b01, 3'b100}) begin
         miscompares++;
         $display("FAIL decode_ff0010: got s_cyc=%b dat=%h ack=%b b_s_cyc=%b want 100 a002 01 100",
                  a_s_cyc, a_m_dat, a_m_ack, b_s_cyc);
      end
      vectors++;
      if ({a_s_we, a_s_dat, a_s_sel} !== {1'b1, 16'h1234, 2'b10}) begin
         miscompares++;
         $display("FAIL req_mux: got we=%b dat=%h sel=%b want 1 1234 10", a_s_we, a_s_dat, a_s_sel);
      end
      tick();
      m_we[0] = 1'b0;
      m_adr[23:0] = 24'h000100;
      mid();
      vectors++;
      if ({a_s_cyc, a_m_dat, a_m_ack, a_m_err} !== {3'b001, 16'hA000, 2'b01, 2'b00}) begin
         miscompares++;
         $display("FAIL decode_slave0: got s_cyc=%b dat=%h ack=%b err=%b want 001 a000 01 00",
                  a_s_cyc, a_m_dat, a_m_ack, a_m_err);
      end
      vectors++;
      if ({b_s_cyc, b_m_dat, b_m_ack, b_m_err} !== {3'b000, 16'h0000, 2'b00, 2'b01}) begin
         miscompares++;
         $display("FAIL decode_unmapped: got s_cyc=%b dat=%h ack=%b err=%b want 000 0000 00 01",
                  b_s_cyc, b_m_dat, b_m_ack, b_m_err);
      end
      tick();
      drive(0, 1'b0, 1'b0, 24'h0);
      m_sel = '0;
      m_dat = '0;
      tick();
   endtask

   task automatic test_timeout();
      ack_en = 1'b0;
      drive(0, 1'b1, 1'b1, 24'h000010);
      tick();
      mid();
      vectors++;
      if ({a_gnt, a_m_err, a_s_stb} !== {2'b01, 2'b00, 3'b001}) begin
         miscompares++;
         $display("FAIL tmo_start: got gnt=%b err=%b s_stb=%b want 01 00 001", a_gnt, a_m_err, a_s_stb);
      end
`ifdef WB_SHARED_BUS_TIMEOUT_EN
      for (int i = 1; i <= 8; i++) begin
         tick();
         mid();
         vectors++;
         if ({a_m_err, a_s_stb} !== ((i == 8) ? {2'b01, 3'b000} : {2'b00, 3'b001})) begin
            miscompares++;
            $display("FAIL tmo_cycle%0d: got err=%b s_stb=%b want %s", i, a_m_err, a_s_stb,
                     (i == 8) ? "01 000" : "00 001");
         end
      end
      tick();
      drive(0, 1'b0, 1'b0, 24'h0);
      mid();
      vectors++;
      if (a_m_err !== 2'b00) begin
         miscompares++;
         $display("FAIL tmo_single_pulse: got err=%b want 00", a_m_err);
      end
`else
      begin
         int err_cycles = 0;
         for (int i = 0; i < 1000; i++) begin
            tick();
            mid();
            if (a_m_err !== 2'b00)
               err_cycles++;
         end
         vectors++;
         if (err_cycles !== 0) begin
            miscompares++;
            $display("FAIL no_watchdog: got %0d err cycles want 0", err_cycles);
         end
      end
      tick();
      drive(0, 1'b0, 1'b0, 24'h0);
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      tick();
      drive(0, 1'b1, 1'b1, 24'h000020);
      m_we[0] = 1'b1;
      ack_force = 3'b001;
      tick();
      mid();
      vectors++;
      if ({a_gnt, a_m_ack} !== {2'b01, 2'b01}) begin
         miscompares++;
         $display("FAIL pre_reset_write: got gnt=%b ack=%b want 01 01", a_gnt, a_m_ack);
      end
      tick();
      rst = 1'b1;
      drive(1, 1'b1, 1'b1, 24'h400000);
      #1;
      vectors++;
      if ({a_gnt, a_s_cyc, a_s_stb, a_m_ack, a_m_err, a_s_adr} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_write: got gnt=%b s_cyc=%b s_stb=%b ack=%b err=%b adr=%h want all zero",
                  a_gnt, a_s_cyc, a_s_stb, a_m_ack, a_m_err, a_s_adr);
      end
      mid();
      rst = 1'b0;
      ack_force = '0;
      tick();
      mid();
      vectors++;
      if (a_gnt !== 2'b01) begin
         miscompares++;
         $display("FAIL post_reset_priority: got gnt=%b want 01", a_gnt);
      end
      tick();
      m_cyc = '0;
      m_stb = '0;
      m_we = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_bus_lock();
      test_decode();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "time limit");
   end
endmodule
